// File: rtl/idu_issue_ctrl.sv
// Issue scheduler between instruction fetch and the decode/CU path.
// Fetched words wait in a small FIFO; a register scoreboard holds back
// instructions whose operands or destination are still being written.
// Control-flow, fence/ecall and halting opcodes are serialised by an FSM.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | normal issue, at most one instruction per cycle
//   ST_BR_WAIT | branch/jump issued, waiting for the CU to resolve it
//   ST_HALT    | ebreak or invalid opcode at head; left only by IDU_reset
module idu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             soc_clk,
    input  logic             IDU_reset,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_ready,
    input  logic             idu_stall,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [31:0]      issue_instr,
    output logic [31:0]      issue_pc,
    output logic [1:0]       issue_bypass,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             redirect_done,
    input  logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]      r_mem_instr [DEPTH];
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [31:0]      r_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_head_instr;
    logic [31:0] w_head_pc;
    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_rd_used;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_ctrl;
    logic        w_drain;
    logic        w_ebreak;
    logic        w_invalid;
    logic        w_rs1_busy;
    logic        w_rs2_busy;
    logic        w_rs1_wb;
    logic        w_rs2_wb;
    logic        w_haz_raw;
    logic        w_haz_waw;
    logic        w_drain_block;
    logic        w_can_issue;
    logic        w_stall_evt;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

    assign w_head_instr = r_mem_instr[r_rptr[AW-1:0]];
    assign w_head_pc    = r_mem_pc[r_rptr[AW-1:0]];
    assign w_opc        = w_head_instr[6:0];
    assign w_rd         = w_head_instr[11:7];
    assign w_rs1        = w_head_instr[19:15];
    assign w_rs2        = w_head_instr[24:20];

    // Field usage and instruction class of the FIFO head
    always_comb begin
        w_rd_used  = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_ctrl     = 1'b0;
        w_drain    = 1'b0;
        w_ebreak   = 1'b0;
        w_invalid  = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: w_rd_used = 1'b1;
            OPC_JAL: begin
                w_rd_used = 1'b1;
                w_ctrl    = 1'b1;
            end
            OPC_JALR: begin
                w_rd_used  = 1'b1;
                w_rs1_used = 1'b1;
                w_ctrl     = 1'b1;
            end
            OPC_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_ctrl     = 1'b1;
            end
            OPC_STORE: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM: begin
                w_rd_used  = 1'b1;
                w_rs1_used = 1'b1;
            end
            OPC_OP: begin
                w_rd_used  = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_FENCE: w_drain = 1'b1;
            OPC_SYSTEM: begin
                w_ebreak = w_head_instr[20];
                w_drain  = ~w_head_instr[20];
            end
            default: w_invalid = 1'b1;
        endcase
    end

    // A busy source whose write retires this cycle is forwarded, not stalled
    assign w_rs1_busy = w_rs1_used && (w_rs1 != 5'd0) && r_busy[w_rs1];
    assign w_rs2_busy = w_rs2_used && (w_rs2 != 5'd0) && r_busy[w_rs2];
    assign w_rs1_wb   = wb_valid && (wb_rd == w_rs1);
    assign w_rs2_wb   = wb_valid && (wb_rd == w_rs2);
    assign w_haz_raw  = (w_rs1_busy && !w_rs1_wb) || (w_rs2_busy && !w_rs2_wb);
    assign w_haz_waw  = w_rd_used && (w_rd != 5'd0) && r_busy[w_rd]
                        && !(wb_valid && (wb_rd == w_rd));
    assign w_drain_block = w_drain && (r_busy != 32'd0);

    // Nothing issues during flush: the head is being discarded that cycle
    assign w_can_issue = !w_empty && (r_state == ST_RUN) && !idu_stall && !flush
                         && !w_haz_raw && !w_haz_waw && !w_drain_block
                         && !w_invalid && !w_ebreak;

    assign w_push = fetch_valid && !w_full && !flush;
    assign w_pop  = w_can_issue && issue_ready;

    assign fetch_ready  = !w_full;
    assign issue_valid  = w_can_issue;
    assign issue_instr  = w_empty ? 32'd0 : w_head_instr;
    assign issue_pc     = w_empty ? 32'd0 : w_head_pc;
    assign issue_bypass = w_can_issue ? {w_rs2_busy && w_rs2_wb, w_rs1_busy && w_rs1_wb} : 2'b00;
    assign halted       = (r_state == ST_HALT);
    assign stall_count  = r_stall_cnt;

    assign w_busy_set  = (w_pop && w_rd_used && (w_rd != 5'd0)) ? (32'd1 << w_rd) : 32'd0;
    assign w_busy_clr  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign w_stall_evt = !w_empty && !w_can_issue && (r_state != ST_HALT);

    // FIFO storage; contents are only visible through valid pointers
    always_ff @(posedge soc_clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr[AW-1:0]] <= fetch_instr;
            r_mem_pc[r_wptr[AW-1:0]]    <= fetch_pc;
        end
    end

    // FIFO pointers; flush empties the queue and drops a same-cycle push
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Scoreboard: retirement clears, issue sets (set wins), x0 never busy
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & 32'hFFFF_FFFE;
        end
    end

    // Saturating count of cycles with work queued but nothing issued
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    // FSM state register
    always_ff @(posedge soc_clk or posedge IDU_reset) begin
        if (IDU_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state; flush releases a branch wait but never leaves HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (!flush) begin
                    if (!w_empty && (w_invalid || w_ebreak)) begin
                        w_state_nxt = ST_HALT;
                    end else if (w_pop && w_ctrl) begin
                        w_state_nxt = ST_BR_WAIT;
                    end
                end
            end
            ST_BR_WAIT: begin
                if (flush || redirect_done) w_state_nxt = ST_RUN;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

endmodule
